// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Word-addressed memory slave for a simple accumulator controller.
//            It handles level-held rd/wr strobes with an optional number of
//            wait states, a program-preload write port, and a sticky
//            protocol-error flag.
// Ports    : clk        - rising-edge clock
//            rst        - asynchronous, active-low reset
//            addr       - access address (latched at access start)
//            rd, wr     - level-held read / write strobes
//            data_e     - controller drives data_in (sampled at write time)
//            data_in    - write data
//            data_out   - registered read data, valid while data_oe=1
//            data_oe    - responder owns the data bus
//            ready      - access complete (level for reads, pulse for writes)
//            load_en, load_addr, load_data - preload write port (idle only)
//            err        - sticky protocol error, cleared only by reset
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int AW          = 5,
  parameter int DW          = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          rd,
  input  logic          wr,
  input  logic          data_e,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          data_oe,
  output logic          ready,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  output logic          err
);

  localparam logic [2:0] c_st_idle     = 3'd0;
  localparam logic [2:0] c_st_rd_wait  = 3'd1;
  localparam logic [2:0] c_st_rd_drive = 3'd2;
  localparam logic [2:0] c_st_wr_wait  = 3'd3;
  localparam logic [2:0] c_st_wr_done  = 3'd4;

  localparam int         c_depth   = 1 << AW;
  localparam bit         c_no_wait = (WAIT_STATES == 0);
  // The wait counter is loaded with WAIT_STATES-1 and the access completes
  // on the edge where it reads zero, so the wait state lasts exactly
  // WAIT_STATES cycles.
  localparam logic [2:0] c_ws_m1   = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  logic [DW-1:0] r_mem [c_depth];

  logic [2:0]    r_state;
  logic [2:0]    r_cnt;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data_out;
  logic          r_data_oe;
  logic          r_ready;
  logic          r_err;

  logic          w_idle_quiet;
  logic          w_load_ok;
  logic          w_wr_sample;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_waddr;
  logic [DW-1:0] w_mem_wdata;

  // Preload is accepted only in IDLE with both strobes low.
  assign w_idle_quiet = (r_state == c_st_idle) && !rd && !wr;
  assign w_load_ok    = load_en && w_idle_quiet;

  // Edge at which data_e is sampled: directly from IDLE with no wait states,
  // otherwise the last WR_WAIT cycle.
  assign w_wr_sample  = ((r_state == c_st_idle) && wr && !rd && c_no_wait) ||
                        ((r_state == c_st_wr_wait) && (r_cnt == 3'd0));

  // Gating with rst keeps a reset edge from committing a half-finished write.
  assign w_mem_we     = rst && (w_load_ok || (w_wr_sample && data_e));
  assign w_mem_waddr  = w_load_ok ? load_addr :
                        ((r_state == c_st_idle) ? addr : r_addr);
  assign w_mem_wdata  = w_load_ok ? load_data : data_in;

  // Storage has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_st_idle;
      r_cnt      <= 3'd0;
      r_addr     <= '0;
      r_data_out <= '0;
      r_data_oe  <= 1'b0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_data_oe <= 1'b0;
      r_ready   <= 1'b0;

      if ((rd && wr) || (load_en && !w_idle_quiet)) begin
        r_err <= 1'b1;
      end

      case (r_state)
        c_st_idle: begin
          if (rd && !wr) begin
            r_addr <= addr;
            if (c_no_wait) begin
              // Read straight from the incoming address so data is valid
              // in the very first RD_DRIVE cycle.
              r_state    <= c_st_rd_drive;
              r_data_out <= r_mem[addr];
              r_data_oe  <= 1'b1;
              r_ready    <= 1'b1;
            end else begin
              r_state <= c_st_rd_wait;
              r_cnt   <= c_ws_m1;
            end
          end else if (wr && !rd) begin
            r_addr <= addr;
            if (c_no_wait) begin
              r_state <= c_st_wr_done;
              if (data_e) begin
                r_ready <= 1'b1;
              end else begin
                r_err <= 1'b1;
              end
            end else begin
              r_state <= c_st_wr_wait;
              r_cnt   <= c_ws_m1;
            end
          end
        end

        c_st_rd_wait: begin
          if (r_cnt == 3'd0) begin
            r_state    <= c_st_rd_drive;
            r_data_out <= r_mem[r_addr];
            r_data_oe  <= 1'b1;
            r_ready    <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end

        c_st_rd_drive: begin
          if (rd) begin
            r_data_out <= r_mem[r_addr];
            r_data_oe  <= 1'b1;
            r_ready    <= 1'b1;
          end else begin
            r_state <= c_st_idle;
          end
        end

        c_st_wr_wait: begin
          if (r_cnt == 3'd0) begin
            r_state <= c_st_wr_done;
            if (data_e) begin
              r_ready <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end

        c_st_wr_done: begin
          // Stay here for the rest of the wr pulse: one write per pulse.
          if (!wr) begin
            r_state <= c_st_idle;
          end
        end

        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign data_out = r_data_out;
  assign data_oe  = r_data_oe;
  assign ready    = r_ready;
  assign err      = r_err;

endmodule
`default_nettype wire
